bvb_mac_drain: RTL

//  Consumer of the banked vector buffer's per-channel vec FIFOs. Each channel pops one

---
 rtl/bvb_mac_drain_if.sv | 33 +++
 rtl/bvb_mac_drain.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bvb_mac_drain_if.sv
// Connection bundle between bvb_mac_drain, the banked vector buffer's per-channel
// vec/matrix FIFOs and the downstream result writer.
interface bvb_mac_drain_if #(
    parameter int CHANNEL_NUM = 4,
    parameter int VAL_BITS    = 8,
    parameter int ACC_BITS    = 32,
    parameter int ROW_BITS    = 16
);
    localparam int CH_BITS = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    logic [CHANNEL_NUM*VAL_BITS-1:0] vec;
    logic [CHANNEL_NUM-1:0]          vec_fifo_empty;
    logic [CHANNEL_NUM-1:0]          vec_fifo_read;
    logic [CHANNEL_NUM*VAL_BITS-1:0] mat_val;
    logic [CHANNEL_NUM-1:0]          mat_last;
    logic [CHANNEL_NUM-1:0]          mat_fifo_empty;
    logic [CHANNEL_NUM-1:0]          mat_fifo_read;
    logic                            res_valid;
    logic                            res_ready;
    logic [ACC_BITS-1:0]             res_data;
    logic [CH_BITS-1:0]              res_channel;
    logic [ROW_BITS-1:0]             res_row;

    modport master (
        input  vec, vec_fifo_empty, mat_val, mat_last, mat_fifo_empty, res_ready,
        output vec_fifo_read, mat_fifo_read, res_valid, res_data, res_channel, res_row
    );

    modport slave (
        output vec, vec_fifo_empty, mat_val, mat_last, mat_fifo_empty, res_ready,
        input  vec_fifo_read, mat_fifo_read, res_valid, res_data, res_channel, res_row
    );
endinterface

// File: rtl/bvb_mac_drain.sv
// Per-channel multiply-accumulate over paired vec/matrix FIFOs; finished row sums are
// parked per channel and round-robin arbitrated onto a single result stream.
module bvb_mac_drain #(
    parameter int CHANNEL_NUM = 4,
    parameter int VAL_BITS    = 8,
    parameter int ACC_BITS    = 32,
    parameter int ROW_BITS    = 16
) (
    input  logic            clk,
    input  logic            rst,
    bvb_mac_drain_if.master bus
);
    localparam int CH_BITS   = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int PROD_BITS = 2 * VAL_BITS;

    typedef logic [VAL_BITS-1:0]    val_t;
    typedef logic [PROD_BITS-1:0]   prod_t;
    typedef logic [ACC_BITS-1:0]    acc_t;
    typedef logic [ROW_BITS-1:0]    row_t;
    typedef logic [CH_BITS-1:0]     ch_t;
    typedef logic [CHANNEL_NUM-1:0] mask_t;

    mask_t pop_q,      pop_d;
    mask_t s1_valid_q, s1_valid_d;
    mask_t s1_last_q,  s1_last_d;
    mask_t s2_valid_q, s2_valid_d;
    mask_t s2_last_q,  s2_last_d;
    mask_t hold_q,     hold_d;

    val_t  s1_vec_q    [CHANNEL_NUM];
    val_t  s1_vec_d    [CHANNEL_NUM];
    val_t  s1_mat_q    [CHANNEL_NUM];
    val_t  s1_mat_d    [CHANNEL_NUM];
    prod_t s2_prod_q   [CHANNEL_NUM];
    prod_t s2_prod_d   [CHANNEL_NUM];
    acc_t  acc_q       [CHANNEL_NUM];
    acc_t  acc_d       [CHANNEL_NUM];
    acc_t  hold_data_q [CHANNEL_NUM];
    acc_t  hold_data_d [CHANNEL_NUM];
    row_t  hold_row_q  [CHANNEL_NUM];
    row_t  hold_row_d  [CHANNEL_NUM];
    row_t  row_cnt_q   [CHANNEL_NUM];
    row_t  row_cnt_d   [CHANNEL_NUM];

    logic  res_valid_q,   res_valid_d;
    acc_t  res_data_q,    res_data_d;
    ch_t   res_channel_q, res_channel_d;
    row_t  res_row_q,     res_row_d;
    ch_t   ptr_q,         ptr_d;

    mask_t rd;
    mask_t last_inflight;
    mask_t hold_set;
    mask_t hold_clr;
    logic  hs;
    logic  found;
    ch_t   gnt;

    function automatic ch_t next_ch(input ch_t c);
        return (int'(c) == CHANNEL_NUM - 1) ? '0 : ch_t'(c + 1'b1);
    endfunction

    // Channel datapath: pop -> stage-1 capture -> product -> accumulate / park row sum.
    always_comb begin
        acc_t acc_sum;
        // NOTE: every combinational output gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        acc_sum       = '0;
        last_inflight = '0;
        rd            = '0;
        hold_set      = '0;
        pop_d         = '0;
        s1_valid_d    = '0;
        s1_last_d     = '0;
        s2_valid_d    = '0;
        s2_last_d     = '0;
        hold_d        = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            last_inflight[i] = (pop_q[i] & bus.mat_last[i])
                             | (s1_valid_q[i] & s1_last_q[i])
                             | (s2_valid_q[i] & s2_last_q[i]);
            // Gated by reset so nothing is popped while the pipeline is held cleared.
            rd[i] = rst & ~bus.vec_fifo_empty[i] & ~bus.mat_fifo_empty[i]
                  & ~hold_q[i] & ~last_inflight[i];

            pop_d[i]      = rd[i];
            s1_valid_d[i] = pop_q[i];
            s1_last_d[i]  = pop_q[i] & bus.mat_last[i];
            s1_vec_d[i]   = pop_q[i] ? bus.vec[i*VAL_BITS +: VAL_BITS] : s1_vec_q[i];
            s1_mat_d[i]   = pop_q[i] ? bus.mat_val[i*VAL_BITS +: VAL_BITS] : s1_mat_q[i];

            s2_valid_d[i] = s1_valid_q[i];
            s2_last_d[i]  = s1_valid_q[i] & s1_last_q[i];
            s2_prod_d[i]  = s1_valid_q[i] ? prod_t'(s1_vec_q[i]) * prod_t'(s1_mat_q[i])
                                          : s2_prod_q[i];

            acc_sum        = acc_q[i] + acc_t'(s2_prod_q[i]);
            acc_d[i]       = acc_q[i];
            hold_data_d[i] = hold_data_q[i];
            hold_row_d[i]  = hold_row_q[i];
            row_cnt_d[i]   = row_cnt_q[i];
            if (s2_valid_q[i]) begin
                if (s2_last_q[i]) begin
                    hold_data_d[i] = acc_sum;
                    acc_d[i]       = '0;
                    hold_set[i]    = 1'b1;
                    hold_row_d[i]  = row_cnt_q[i];
                    row_cnt_d[i]   = row_cnt_q[i] + 1'b1;
                end else begin
                    acc_d[i] = acc_sum;
                end
            end
            hold_d[i] = (hold_q[i] & ~hold_clr[i]) | hold_set[i];
        end
    end

    // Result arbiter: rescans on an idle output or on the handshake cycle itself, so a
    // parked row from another channel can follow back-to-back.
    always_comb begin
        ch_t   scan_ptr;
        ch_t   sel;
        mask_t cand;
        int    idx;
        idx           = 0;
        sel           = '0;
        hs            = res_valid_q & bus.res_ready;
        scan_ptr      = hs ? next_ch(res_channel_q) : ptr_q;
        hold_clr      = '0;
        if (hs) hold_clr[res_channel_q] = 1'b1;
        cand          = hold_q & ~hold_clr;
        found         = 1'b0;
        gnt           = '0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            idx = int'(scan_ptr) + k;
            if (idx >= CHANNEL_NUM) idx = idx - CHANNEL_NUM;
            sel = ch_t'(idx);
            if (!found && cand[sel]) begin
                found = 1'b1;
                gnt   = sel;
            end
        end

        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_channel_d = res_channel_q;
        res_row_d     = res_row_q;
        ptr_d         = ptr_q;
        if (hs) begin
            res_valid_d = 1'b0;
            ptr_d       = next_ch(res_channel_q);
        end
        if ((!res_valid_q || hs) && found) begin
            res_valid_d   = 1'b1;
            res_data_d    = hold_data_q[gnt];
            res_channel_d = gnt;
            res_row_d     = hold_row_q[gnt];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_q         <= '0;
            s1_valid_q    <= '0;
            s1_last_q     <= '0;
            s2_valid_q    <= '0;
            s2_last_q     <= '0;
            hold_q        <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_channel_q <= '0;
            res_row_q     <= '0;
            ptr_q         <= '0;
            // NOTE: the per-channel arrays are few flops each, not RAM, so they take the
            // reset too and an aborted row can never leak into the next result.
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                s1_vec_q[i]    <= '0;
                s1_mat_q[i]    <= '0;
                s2_prod_q[i]   <= '0;
                acc_q[i]       <= '0;
                hold_data_q[i] <= '0;
                hold_row_q[i]  <= '0;
                row_cnt_q[i]   <= '0;
            end
        end else begin
            // NOTE: non-blocking updates let every stage sample its predecessor's
            // pre-edge value regardless of statement order.
            pop_q         <= pop_d;
            s1_valid_q    <= s1_valid_d;
            s1_last_q     <= s1_last_d;
            s2_valid_q    <= s2_valid_d;
            s2_last_q     <= s2_last_d;
            hold_q        <= hold_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_channel_q <= res_channel_d;
            res_row_q     <= res_row_d;
            ptr_q         <= ptr_d;
            s1_vec_q      <= s1_vec_d;
            s1_mat_q      <= s1_mat_d;
            s2_prod_q     <= s2_prod_d;
            acc_q         <= acc_d;
            hold_data_q   <= hold_data_d;
            hold_row_q    <= hold_row_d;
            row_cnt_q     <= row_cnt_d;
        end
    end

    assign bus.vec_fifo_read = rd;
    assign bus.mat_fifo_read = rd;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_data      = res_data_q;
    assign bus.res_channel   = res_channel_q;
    assign bus.res_row       = res_row_q;
endmodule
